// File: rtl/lcd_display_scanner_if.sv
// Purpose: bundles the register-file read port and the HD44780 pin bus used by lcd_display_scanner.
// Signals: readAddr/readData (register file read port), lcdRs/lcdRw/lcdE/lcdData (LCD pins).
// Modports: master = scanner side (drives address and pins), slave = register file / panel side.
interface lcd_display_scanner_if;
  logic [4:0] readAddr;
  logic [7:0] readData;
  logic       lcdRs;
  logic       lcdRw;
  logic       lcdE;
  logic [7:0] lcdData;

  modport master (
    output readAddr,
    input  readData,
    output lcdRs,
    output lcdRw,
    output lcdE,
    output lcdData
  );

  modport slave (
    input  readAddr,
    output readData,
    input  lcdRs,
    input  lcdRw,
    input  lcdE,
    input  lcdData
  );
endinterface

// File: rtl/lcd_display_scanner.sv
// Purpose: initialises a 2x16 HD44780-class LCD, then scans register file bytes 0..31 onto rows 0/1.
// Latency: per byte 1 (setup) + E_PULSE_CYCLES + CMD/CLEAR wait; a character adds a 2-cycle fetch first.
// Backpressure: none; refreshEn is sampled only at the end of a transaction's wait, so a strobe is never cut short.
//
// Ports: clk, resetN (async active-low), refreshEn (scan enable), bus (master modport: readAddr/readData,
//        lcdRs/lcdRw/lcdE/lcdData), initDone (sticky after init), frameDone (1-cycle pulse after char 31).
// Build option: define LCD_FOUR_BIT_EN for the 4-bit panel interface (nibbles on lcdData[7:4]).
module lcd_display_scanner #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int E_PULSE_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000,
  parameter int CNT_W             = 20
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 refreshEn,
  lcd_display_scanner_if.master bus,
  output logic                 initDone,
  output logic                 frameDone
);

  // Every wait loads N-1 and counts down to zero, giving exactly N cycles.
  localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] E_LD   = CNT_W'(E_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LD = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

`ifdef LCD_FOUR_BIT_EN
  localparam logic [2:0] INIT_LAST = 3'd7;
`else
  localparam logic [2:0] INIT_LAST = 3'd3;
`endif

  typedef enum logic [2:0] {
    PWRUP,
    IDLE,
    FETCH,
    SETUP,
    EHIGH,
    GAP,
    WAIT
  } state_t;

  state_t           state, stateN;
  logic [CNT_W-1:0] cnt, cntN;
  logic [4:0]       idx, idxN;
  logic [4:0]       readAddr, readAddrN;
  logic [2:0]       initStep, initStepN;
  logic             fetchPhase, fetchPhaseN;
  logic [7:0]       curByte, curByteN;
  logic             lcdRs, lcdRsN;
  logic             lcdE, lcdEN;
  logic [7:0]       lcdData, lcdDataN;
  logic             initDoneN, frameDoneN;

  // Request to start a new byte transaction; resolved at the bottom of the next-state logic.
  logic             launch;
  logic [7:0]       launchByte;
  logic             launchRs;
  logic             isClear;

`ifdef LCD_FOUR_BIT_EN
  // lowNib=1 means the nibble on the bus is the last one of this transaction.
  // Nibble-only init writes start with lowNib=1 so they go straight to the wait.
  logic lowNib, lowNibN;
  logic launchNib;

  function automatic logic [7:0] initByte(input logic [2:0] step);
    case (step)
      3'd0, 3'd1, 3'd2: initByte = 8'h03;
      3'd3:             initByte = 8'h02;
      3'd4:             initByte = 8'h28;
      3'd5:             initByte = 8'h0C;
      3'd6:             initByte = 8'h01;
      default:          initByte = 8'h06;
    endcase
  endfunction

  function automatic logic initNibOnly(input logic [2:0] step);
    initNibOnly = (step < 3'd4);
  endfunction
`else
  function automatic logic [7:0] initByte(input logic [2:0] step);
    case (step)
      3'd0:    initByte = 8'h38;
      3'd1:    initByte = 8'h0C;
      3'd2:    initByte = 8'h01;
      default: initByte = 8'h06;
    endcase
  endfunction
`endif

  // The clear-display command needs the long wait.
  assign isClear = !lcdRs && (curByte == 8'h01);

  always_comb begin
    stateN      = state;
    cntN        = cnt;
    idxN        = idx;
    readAddrN   = readAddr;
    initStepN   = initStep;
    fetchPhaseN = fetchPhase;
    curByteN    = curByte;
    lcdRsN      = lcdRs;
    lcdEN       = 1'b0;
    lcdDataN    = lcdData;
    initDoneN   = initDone;
    frameDoneN  = 1'b0;
    launch      = 1'b0;
    launchByte  = 8'h00;
    launchRs    = 1'b0;
`ifdef LCD_FOUR_BIT_EN
    lowNibN     = lowNib;
    launchNib   = 1'b0;
`endif

    case (state)
      PWRUP: begin
        if (cnt == '0) begin
          launch     = 1'b1;
          launchByte = initByte(3'd0);
`ifdef LCD_FOUR_BIT_EN
          launchNib  = initNibOnly(3'd0);
`endif
        end else begin
          cntN = cnt - ONE;
        end
      end

      IDLE: begin
        // Only reachable after init, so refreshEn is honoured here; a frame always restarts at row 0.
        if (refreshEn) begin
          launch     = 1'b1;
          launchByte = 8'h80;
        end
      end

      FETCH: begin
        // Two cycles so a registered read port has its data ready by the capture edge.
        if (!fetchPhase) begin
          fetchPhaseN = 1'b1;
        end else begin
          fetchPhaseN = 1'b0;
          launch      = 1'b1;
          launchByte  = bus.readData;
          launchRs    = 1'b1;
        end
      end

      SETUP: begin
        stateN = EHIGH;
        cntN   = E_LD;
        lcdEN  = 1'b1;
      end

      EHIGH: begin
        if (cnt != '0) begin
          cntN  = cnt - ONE;
          lcdEN = 1'b1;
        end else begin
`ifdef LCD_FOUR_BIT_EN
          if (!lowNib) begin
            stateN = GAP;
            cntN   = E_LD;
          end else begin
            stateN = WAIT;
            cntN   = isClear ? CLR_LD : CMD_LD;
          end
`else
          stateN = WAIT;
          cntN   = isClear ? CLR_LD : CMD_LD;
`endif
        end
      end

`ifdef LCD_FOUR_BIT_EN
      GAP: begin
        if (cnt != '0) begin
          cntN = cnt - ONE;
        end else begin
          stateN   = SETUP;
          lowNibN  = 1'b1;
          lcdDataN = {curByte[3:0], 4'h0};
        end
      end
`endif

      WAIT: begin
        if (cnt != '0) begin
          cntN = cnt - ONE;
        end else if (!initDone) begin
          if (initStep == INIT_LAST) begin
            initDoneN = 1'b1;
            stateN    = IDLE;
          end else begin
            initStepN  = initStep + 3'd1;
            launch     = 1'b1;
            launchByte = initByte(initStep + 3'd1);
`ifdef LCD_FOUR_BIT_EN
            launchNib  = initNibOnly(initStep + 3'd1);
`endif
          end
        end else begin
          // Frame end pulses even when the scan is being stopped at this boundary.
          if (lcdRs && (idx == 5'd31)) begin
            frameDoneN = 1'b1;
          end
          if (!refreshEn) begin
            stateN = IDLE;
            idxN   = 5'd0;
          end else if (!lcdRs) begin
            // An address command was just written: fetch the character for idx.
            stateN      = FETCH;
            readAddrN   = idx;
            fetchPhaseN = 1'b0;
          end else if (idx == 5'd31) begin
            idxN       = 5'd0;
            launch     = 1'b1;
            launchByte = 8'h80;
          end else if (idx == 5'd15) begin
            idxN       = 5'd16;
            launch     = 1'b1;
            launchByte = 8'hC0;
          end else begin
            idxN        = idx + 5'd1;
            stateN      = FETCH;
            readAddrN   = idx + 5'd1;
            fetchPhaseN = 1'b0;
          end
        end
      end

      default: begin
        stateN = PWRUP;
        cntN   = PWR_LD;
      end
    endcase

    // Start a transaction: bus values are set up here and held until the wait ends.
    if (launch) begin
      stateN   = SETUP;
      curByteN = launchByte;
      lcdRsN   = launchRs;
`ifdef LCD_FOUR_BIT_EN
      lowNibN  = launchNib;
      lcdDataN = launchNib ? {launchByte[3:0], 4'h0} : {launchByte[7:4], 4'h0};
`else
      lcdDataN = launchByte;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= PWRUP;
      cnt        <= PWR_LD;
      idx        <= 5'd0;
      readAddr   <= 5'd0;
      initStep   <= 3'd0;
      fetchPhase <= 1'b0;
      curByte    <= 8'h00;
      lcdRs      <= 1'b0;
      lcdE       <= 1'b0;
      lcdData    <= 8'h00;
      initDone   <= 1'b0;
      frameDone  <= 1'b0;
`ifdef LCD_FOUR_BIT_EN
      lowNib     <= 1'b0;
`endif
    end else begin
      state      <= stateN;
      cnt        <= cntN;
      idx        <= idxN;
      readAddr   <= readAddrN;
      initStep   <= initStepN;
      fetchPhase <= fetchPhaseN;
      curByte    <= curByteN;
      lcdRs      <= lcdRsN;
      lcdE       <= lcdEN;
      lcdData    <= lcdDataN;
      initDone   <= initDoneN;
      frameDone  <= frameDoneN;
`ifdef LCD_FOUR_BIT_EN
      lowNib     <= lowNibN;
`endif
    end
  end

  assign bus.readAddr = readAddr;
  assign bus.lcdRs    = lcdRs;
  assign bus.lcdRw    = 1'b0;
  assign bus.lcdE     = lcdE;
  assign bus.lcdData  = lcdData;

endmodule

// File: tb/tb_lcd_display_scanner.sv
// Purpose: self-checking bench for lcd_display_scanner with short timing parameters.
// Expected E-strobes (RS, data, low cycles before the strobe) are queued and checked as strobes appear.
// Hand-written sequences cover power-up timing, stop/restart and reset during a strobe.
`timescale 1ns/1ps
module tb_lcd_display_scanner;
  localparam int POWERUP = 10;
  localparam int EPULSE  = 2;
  localparam int CMDW    = 4;
  localparam int CLRW    = 8;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic refreshEn = 1'b0;
  logic initDone, frameDone;
  logic [7:0] mem [32];

  lcd_display_scanner_if bus();
  assign bus.readData = mem[bus.readAddr];

  lcd_display_scanner #(
    .POWERUP_CYCLES(POWERUP),
    .E_PULSE_CYCLES(EPULSE),
    .CMD_WAIT_CYCLES(CMDW),
    .CLEAR_WAIT_CYCLES(CLRW),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .refreshEn(refreshEn),
    .bus(bus),
    .initDone(initDone),
    .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  // gap: low samples between previous E fall (or reset release) and this E rise; -1 = don't care.
  typedef struct { logic rs; logic [7:0] data; int gap; bit nib; } vec_t;
  typedef struct { logic rs; logic [7:0] data; int gap; } exp_t;

  exp_t expQ[$];
  int nVec = 0;
  int nMis = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  task automatic pushVec(input vec_t v);
    exp_t e;
`ifdef LCD_FOUR_BIT_EN
    if (v.nib) begin
      e = '{v.rs, {v.data[3:0], 4'h0}, v.gap};
      expQ.push_back(e);
    end else begin
      e = '{v.rs, {v.data[7:4], 4'h0}, v.gap};
      expQ.push_back(e);
      e = '{v.rs, {v.data[3:0], 4'h0}, EPULSE + 1};
      expQ.push_back(e);
    end
`else
    e = '{v.rs, v.data, v.gap};
    expQ.push_back(e);
`endif
  endtask

  task automatic waitDrain(input int budget, input string what);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (expQ.size() != 0) begin
      nVec++;
      nMis++;
      $display("FAIL %s: timeout with %0d strobes outstanding, required 0", what, expQ.size());
      expQ.delete();
    end
  endtask

  // Strobe monitor, sampling on the falling clock edge.
  logic prevE = 1'b0;
  logic prevFd = 1'b0;
  int lowRun = 0;
  int highRun = 0;
  int pulseCnt = 0;
  int fdCnt = 0;
  int fdAtPulse = -1;
  int initLow = -1;
  logic riseRs;
  logic [7:0] riseData;
  exp_t monE;

  always @(negedge clk) begin
    if (!resetN) begin
      prevE   = 1'b0;
      prevFd  = 1'b0;
      lowRun  = 0;
      highRun = 0;
    end else begin
      if (bus.lcdE && !prevE) begin
        pulseCnt++;
        highRun  = 1;
        riseRs   = bus.lcdRs;
        riseData = bus.lcdData;
        check("strobe_rw", {31'd0, bus.lcdRw}, 0);
        if (expQ.size() == 0) begin
          nVec++;
          nMis++;
          $display("FAIL unexpected_strobe: got rs=%0d data=0x%0h, required no strobe", riseRs, riseData);
        end else begin
          monE = expQ.pop_front();
          check("strobe_rs", {31'd0, riseRs}, {31'd0, monE.rs});
          check("strobe_data", {24'd0, riseData}, {24'd0, monE.data});
          if (monE.gap >= 0) check("strobe_gap", lowRun, monE.gap);
        end
        lowRun = 0;
      end else if (bus.lcdE) begin
        highRun++;
      end else begin
        if (prevE) begin
          check("strobe_width", highRun, EPULSE);
          check("strobe_data_hold", {24'd0, bus.lcdData}, {24'd0, riseData});
          check("strobe_rs_hold", {31'd0, bus.lcdRs}, {31'd0, riseRs});
        end
        lowRun++;
      end
      if (initDone && initLow < 0) initLow = lowRun;
      if (frameDone && !prevFd) begin
        fdCnt++;
        fdAtPulse = pulseCnt;
      end
      if (prevFd) check("framedone_width", {31'd0, frameDone}, 0);
      prevE  = bus.lcdE;
      prevFd = frameDone;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t initTbl[$];
    int pc;
    logic [7:0] firstSetup;
    int framePulses;

    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h41 + i);

`ifdef LCD_FOUR_BIT_EN
    initTbl.push_back('{1'b0, 8'h03, POWERUP + 1, 1'b1});
    initTbl.push_back('{1'b0, 8'h03, CMDW + 1, 1'b1});
    initTbl.push_back('{1'b0, 8'h03, CMDW + 1, 1'b1});
    initTbl.push_back('{1'b0, 8'h02, CMDW + 1, 1'b1});
    initTbl.push_back('{1'b0, 8'h28, CMDW + 1, 1'b0});
    initTbl.push_back('{1'b0, 8'h0C, CMDW + 1, 1'b0});
    initTbl.push_back('{1'b0, 8'h01, CMDW + 1, 1'b0});
    initTbl.push_back('{1'b0, 8'h06, CLRW + 1, 1'b0});
    firstSetup  = 8'h30;
    framePulses = 12 + 34 * 2;
`else
    initTbl.push_back('{1'b0, 8'h38, POWERUP + 1, 1'b0});
    initTbl.push_back('{1'b0, 8'h0C, CMDW + 1, 1'b0});
    initTbl.push_back('{1'b0, 8'h01, CMDW + 1, 1'b0});
    initTbl.push_back('{1'b0, 8'h06, CLRW + 1, 1'b0});
    firstSetup  = 8'h38;
    framePulses = 4 + 34;
`endif

    // Reset state; refreshEn high throughout init must not disturb it.
    refreshEn = 1'b1;
    resetN    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lcdE", {31'd0, bus.lcdE}, 0);
    check("rst_lcdData", {24'd0, bus.lcdData}, 0);
    check("rst_lcdRs", {31'd0, bus.lcdRs}, 0);
    check("rst_lcdRw", {31'd0, bus.lcdRw}, 0);
    check("rst_readAddr", {27'd0, bus.readAddr}, 0);
    check("rst_initDone", {31'd0, initDone}, 0);
    check("rst_frameDone", {31'd0, frameDone}, 0);

    foreach (initTbl[k]) pushVec(initTbl[k]);
    pushVec('{1'b0, 8'h80, -1, 1'b0});
    for (int i = 0; i < 16; i++) pushVec('{1'b1, 8'(8'h41 + i), CMDW + 3, 1'b0});
    pushVec('{1'b0, 8'hC0, CMDW + 1, 1'b0});
    for (int i = 16; i < 32; i++) pushVec('{1'b1, 8'(8'h41 + i), CMDW + 3, 1'b0});
    pushVec('{1'b0, 8'h80, CMDW + 1, 1'b0});
    for (int i = 0; i < 6; i++) pushVec('{1'b1, 8'(8'h41 + i), CMDW + 3, 1'b0});

    @(posedge clk);
    #1 resetN = 1'b1;
    for (int k = 0; k < POWERUP; k++) begin
      @(negedge clk);
      check("pwrup_lcdE", {31'd0, bus.lcdE}, 0);
      check("pwrup_lcdData", {24'd0, bus.lcdData}, 0);
    end
    @(negedge clk);
    check("setup_lcdE", {31'd0, bus.lcdE}, 0);
    check("setup_lcdRs", {31'd0, bus.lcdRs}, 0);
    check("setup_lcdData", {24'd0, bus.lcdData}, {24'd0, firstSetup});

    // Runs through a full frame and into the next one up to char idx 5's strobe.
    waitDrain(4000, "frame");
    refreshEn = 1'b0;
    check("initdone_delay", initLow, CMDW + 1);
    check("framedone_count", fdCnt, 1);
    check("framedone_position", fdAtPulse, framePulses);

    pc = pulseCnt;
    repeat (100) @(negedge clk);
    check("stop_no_strobes", pulseCnt, pc);
    check("stop_lcdE_low", {31'd0, bus.lcdE}, 0);
    check("stop_readAddr_hold", {27'd0, bus.readAddr}, 5);
    check("stop_no_framedone", fdCnt, 1);
    check("stop_initDone", {31'd0, initDone}, 1);

    // Restart begins at 0x80/idx 0 and picks up a register write made while stopped.
    mem[1] = 8'h7A;
    pushVec('{1'b0, 8'h80, -1, 1'b0});
    pushVec('{1'b1, 8'h41, CMDW + 3, 1'b0});
    pushVec('{1'b1, 8'h7A, CMDW + 3, 1'b0});
    pushVec('{1'b1, 8'h43, CMDW + 3, 1'b0});
    refreshEn = 1'b1;
    waitDrain(1000, "restart");

    // Asynchronous reset in the middle of a strobe.
    check("strobe_active_before_reset", {31'd0, bus.lcdE}, 1);
    #2 resetN = 1'b0;
    #1;
    check("async_rst_lcdE", {31'd0, bus.lcdE}, 0);
    check("async_rst_lcdData", {24'd0, bus.lcdData}, 0);
    check("async_rst_readAddr", {27'd0, bus.readAddr}, 0);
    check("async_rst_initDone", {31'd0, initDone}, 0);
    refreshEn = 1'b0;
    initLow = -1;
    repeat (2) @(negedge clk);
    foreach (initTbl[k]) pushVec(initTbl[k]);
    @(posedge clk);
    #1 resetN = 1'b1;
    waitDrain(1000, "reinit");
    pc = pulseCnt;
    repeat (30) @(negedge clk);
    check("reinit_initDone", {31'd0, initDone}, 1);
    check("reinit_idle", pulseCnt, pc);
    check("reinit_initdone_delay", initLow, CMDW + 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
